// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, instruction buffer
//
// Owns the fetch PC, issues word requests to instruction memory under a
// credit limit, buffers returned words in a small registered FIFO and hands
// {instr, pc} to decode over a valid/ready handshake. Redirects from execute
// flush the buffer and discard responses that are already in flight.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a misaligned redirect target queues one fault entry
//               {instr=0x13, pc=target, fault=1} and halts fetching until
//               the next redirect or reset.
//   undefined : redirect_pc[1:0] is ignored, out_fault is tied to 0.
//
// Parameters:
//   RESET_PC         PC loaded on reset
//   FIFO_DEPTH       buffer entries (power of 2, >= 2); also the cap on
//                    outstanding requests + buffered entries
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel (addr word aligned)
//   imem_resp_valid/data          in-order response, no backpressure
//   redirect_valid/pc             taken branch/jump pulse and target
//   out_valid/ready               handshake towards decode
//   out_instr, out_pc, out_fault  head of the instruction buffer

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  // Architectural state
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  // Instruction buffer
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // PCs of the requests currently in flight, oldest first
  logic [31:0]   r_rq_pc [FIFO_DEPTH];
  logic [PW-1:0] r_rq_rd;
  logic [PW-1:0] r_rq_wr;

  logic          w_nonempty;
  logic          w_pop;
  logic          w_fire;
  logic          w_push;
  logic          w_halt;
  logic [SW-1:0] w_credit_used;
  logic [31:0]   w_redirect_target;

  // Low two bits are dropped here; the misalign check looks at them separately.
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {ST_FETCH, ST_HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_misalign;
  logic        r_fifo_fault [FIFO_DEPTH];

  assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_next;
  end

  // Any redirect decides the new state; a misaligned one parks the unit.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_misalign ? ST_HALT : ST_FETCH;
    end
  end

  assign w_halt = (r_state == ST_HALT);
`else
  assign w_halt = 1'b0;
`endif

  assign w_nonempty = (r_count != '0);
  assign out_valid  = w_nonempty && !redirect_valid;
  assign w_pop      = out_valid && out_ready;

  // The entry leaving this cycle frees its slot immediately, which is what
  // lets a single-cycle memory sustain one instruction per clock.
  assign w_credit_used = SW'(r_outstanding) + SW'(r_count) - SW'(w_pop);

  assign imem_req_valid = !rst && !redirect_valid && !w_halt &&
                          (w_credit_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  // Responses landing in a redirect cycle or while stale ones are pending are dropped.
  assign w_push = imem_resp_valid && !redirect_valid && (r_drop == '0);

  assign out_instr = w_nonempty ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign out_pc    = w_nonempty ? r_fifo_pc[r_rd_ptr]    : 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
  assign out_fault = w_nonempty ? r_fifo_fault[r_rd_ptr] : 1'b0;
`else
  assign out_fault = 1'b0;
`endif

  // PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC & 32'hFFFF_FFFC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_fire) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Outstanding and drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        // Everything still in flight is stale, including a response arriving now.
        r_drop <= r_outstanding - CW'(imem_resp_valid);
      end else if (imem_resp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  // In-flight request PC queue; occupancy always equals r_outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rq_rd <= '0;
      r_rq_wr <= '0;
    end else begin
      if (w_fire)          r_rq_wr <= r_rq_wr + PW'(1);
      if (imem_resp_valid) r_rq_rd <= r_rq_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_rq_pc[r_rq_wr] <= r_pc;
  end

  // Instruction buffer pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (w_misalign) begin
        r_wr_ptr <= PW'(1);
        r_count  <= CW'(1);
      end else begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end
`else
      r_wr_ptr <= '0;
      r_count  <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Instruction buffer storage (data path, not reset)
  always_ff @(posedge clk) begin
`ifdef FETCH_MISALIGN_CHK_EN
    if (w_misalign) begin
      // Fault marker carries a NOP word and the unmasked target.
      r_fifo_instr[0] <= 32'h0000_0013;
      r_fifo_pc[0]    <= redirect_pc;
      r_fifo_fault[0] <= 1'b1;
    end else if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]    <= r_rq_pc[r_rq_rd];
      r_fifo_fault[r_wr_ptr] <= 1'b0;
    end
`else
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]    <= r_rq_pc[r_rq_rd];
    end
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  typedef struct { logic [31:0] pc; bit stale; int due; } flight_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; bit fault; } entry_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; int cyc; } deliv_t;

  // Model: in-flight requests (with their memory due time) and buffered entries
  flight_t     inflight[$];
  entry_t      fifo[$];
  deliv_t      delivered[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          rst_done;

  int          cyc;
  int          vectors;
  int          miscompares;
  int          lat_min;
  int          lat_max;
  int          dut_fires;
  int          dut_reqv;
  int          start;
  logic [31:0] key;

  logic        t_rst;
  logic        t_redir;
  logic        t_ordy;
  logic        t_qrdy;
  logic [31:0] t_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_deliv(input string tag, input int idx, input logic [31:0] exp_pc);
    chk({tag, "_seen"}, 32'(delivered.size() > idx), 32'd1);
    if (delivered.size() > idx) chk(tag, delivered[idx].pc, exp_pc);
  endtask

  task automatic step();
    bit          resp;
    bit          exp_ov;
    bit          exp_rv;
    bit          pop;
    bit          fire;
    int          used;
    int          due;
    flight_t     f;
    entry_t      e;
    deliv_t      d;
    logic [31:0] exp_opc;
    logic [31:0] exp_oin;
    bit          exp_of;

    @(negedge clk);
    rst            = t_rst;
    redirect_valid = t_redir;
    redirect_pc    = t_rpc;
    out_ready      = t_ordy;
    imem_req_ready = t_qrdy;
    resp = !t_rst && (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? (inflight[0].pc ^ key) : $urandom;
    #1;

    exp_ov  = (fifo.size() > 0) && !t_redir;
    pop     = exp_ov && t_ordy;
    used    = inflight.size() + fifo.size() - (pop ? 1 : 0);
    exp_rv  = !t_rst && !t_redir && !m_halt && (used < DEPTH);
    fire    = exp_rv && t_qrdy;
    exp_opc = (fifo.size() > 0) ? fifo[0].pc    : 32'h0;
    exp_oin = (fifo.size() > 0) ? fifo[0].instr : 32'h0;
    exp_of  = (fifo.size() > 0) ? fifo[0].fault : 1'b0;

    if (rst_done) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_pc", out_pc, exp_opc);
      chk("out_instr", out_instr, exp_oin);
      chk("out_fault", 32'(out_fault), 32'(exp_of));
      if (!t_rst && imem_req_valid) dut_reqv++;
      if (!t_rst && imem_req_valid && t_qrdy) dut_fires++;
      if (out_valid && t_ordy) begin
        d.pc = out_pc; d.instr = out_instr; d.fault = out_fault; d.cyc = cyc;
        delivered.push_back(d);
      end
    end

    if (t_rst) begin
      inflight.delete();
      fifo.delete();
      m_pc     = RPC;
      m_halt   = 1'b0;
      rst_done = 1'b1;
    end else begin
      if (pop) e = fifo.pop_front();
      if (resp) begin
        f = inflight.pop_front();
        if (!f.stale && !t_redir) begin
          e.instr = f.pc ^ key; e.pc = f.pc; e.fault = 1'b0;
          fifo.push_back(e);
        end
      end
      if (t_redir) begin
        fifo.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc   = t_rpc & 32'hFFFF_FFFC;
        m_halt = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        if (t_rpc[1:0] != 2'b00) begin
          e.instr = 32'h0000_0013; e.pc = t_rpc; e.fault = 1'b1;
          fifo.push_back(e);
          m_halt = 1'b1;
        end
`endif
      end
      if (fire) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (inflight.size() > 0 && due <= inflight[$].due) due = inflight[$].due + 1;
        f.pc = m_pc; f.stale = 1'b0; f.due = due;
        inflight.push_back(f);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    t_rst = 1'b1; t_redir = 1'b0;
    run(2);
    t_rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    t_redir = 1'b1; t_rpc = target;
    step();
    t_redir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    t_rst = 1'b1; t_redir = 1'b0; t_ordy = 1'b1; t_qrdy = 1'b1; t_rpc = '0;
    vectors = 0; miscompares = 0; cyc = 0; rst_done = 1'b0; m_halt = 1'b0; m_pc = RPC;
    dut_fires = 0; dut_reqv = 0; key = '0; lat_min = 1; lat_max = 1;

    // 1-cycle memory, word = address, decode always ready
    do_reset();
    delivered.delete();
    start = cyc;
    run(20);
    chk("p1_rate", 32'(delivered.size() >= 17), 32'd1);
    if (delivered.size() > 0) chk("p1_first_latency", 32'(delivered[0].cyc - start), 32'd2);
    chk_deliv("p1_pc0", 0, 32'h0);
    chk_deliv("p1_pc1", 1, 32'h4);
    chk_deliv("p1_pc2", 2, 32'h8);
    if (delivered.size() > 2) chk("p1_instr2", delivered[2].instr, 32'h8);

    // Decode stalled: only two requests may fire
    do_reset();
    t_ordy = 1'b0; dut_fires = 0;
    run(10);
    chk("p2_fires", 32'(dut_fires), 32'd2);
    delivered.delete();
    t_ordy = 1'b1;
    run(6);
    chk_deliv("p2_pc0", 0, 32'h0);
    chk_deliv("p2_pc1", 1, 32'h4);
    chk_deliv("p2_pc2", 2, 32'h8);

    // 3-cycle memory, redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    delivered.delete();
    run(2);
    redirect_to(32'h0000_0100);
    run(12);
    chk_deliv("p3_pc0", 0, 32'h100);
    chk_deliv("p3_pc1", 1, 32'h104);

    // 2-cycle memory, redirect coincides with a response, one more in flight
    lat_min = 2; lat_max = 2;
    do_reset();
    delivered.delete();
    run(2);
    redirect_to(32'h0000_0300);
    run(10);
    chk_deliv("p4_pc0", 0, 32'h300);
    chk_deliv("p4_pc1", 1, 32'h304);

    // PC wrap
    lat_min = 1; lat_max = 1;
    delivered.delete();
    redirect_to(32'hFFFF_FFF8);
    run(8);
    chk_deliv("p5_pc0", 0, 32'hFFFF_FFF8);
    chk_deliv("p5_pc1", 1, 32'hFFFF_FFFC);
    chk_deliv("p5_pc2", 2, 32'h0000_0000);
    if (delivered.size() > 1) chk("p5_instr1", delivered[1].instr, 32'hFFFF_FFFC);

    // Misaligned redirect target
    delivered.delete();
    redirect_to(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHK_EN
    dut_reqv = 0;
    run(10);
    chk("p6_halt_reqv", 32'(dut_reqv), 32'd0);
    chk("p6_entries", 32'(delivered.size()), 32'd1);
    chk_deliv("p6_pc", 0, 32'h0000_0102);
    if (delivered.size() > 0) begin
      chk("p6_instr", delivered[0].instr, 32'h0000_0013);
      chk("p6_fault", 32'(delivered[0].fault), 32'd1);
    end
    delivered.delete();
    redirect_to(32'h0000_0200);
    run(8);
    chk_deliv("p6_resume0", 0, 32'h200);
    chk_deliv("p6_resume1", 1, 32'h204);
`else
    run(8);
    chk_deliv("p6_masked0", 0, 32'h100);
    if (delivered.size() > 0) chk("p6_nofault", 32'(delivered[0].fault), 32'd0);
`endif

    // Randomized traffic against the model
    key = $urandom; lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      t_ordy  = ($urandom_range(3, 0) != 0);
      t_qrdy  = ($urandom_range(3, 0) != 0);
      t_rst   = ($urandom_range(299, 0) == 0);
      t_redir = !t_rst && ($urandom_range(19, 0) == 0);
      t_rpc   = $urandom;
      if ($urandom_range(1, 0) == 0) t_rpc[1:0] = 2'b00;
      if (i % 1000 == 500) begin
        lat_min = $urandom_range(3, 1);
        lat_max = lat_min + $urandom_range(2, 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
